// File: rtl/mem_seq_unit_if.sv
// Core-side request/response and data-memory byte port of the load/store sequencer.
// Latency: none; this file only groups signals.
// Backpressure: the core holds off while busy; there is no queueing of requests.
// Ports (slave = sequencer view):
//   in : start, is_store, size, base_addr, wdata, mem_rdata
//   out: busy, done, rdata, mem_addr, mem_wdata, mem_wen, mem_to_reg
interface mem_seq_unit_if #(
  parameter int W  = 8,
  parameter int AW = 8
);
  logic             start;
  logic             is_store;
  logic             size;
  logic [AW-1:0]    base_addr;
  logic [2*W-1:0]   wdata;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   rdata;
  logic [AW-1:0]    mem_addr;
  logic [W-1:0]     mem_wdata;
  logic             mem_wen;
  logic             mem_to_reg;
  logic [W-1:0]     mem_rdata;

  modport slave (
    input  start, is_store, size, base_addr, wdata, mem_rdata,
    output busy, done, rdata, mem_addr, mem_wdata, mem_wen, mem_to_reg
  );

  modport master (
    output start, is_store, size, base_addr, wdata, mem_rdata,
    input  busy, done, rdata, mem_addr, mem_wdata, mem_wen, mem_to_reg
  );
endinterface

// File: rtl/mem_seq_unit.sv
// Byte/halfword load/store sequencer issuing one byte access per cycle to an 8-bit data memory.
// Latency: byte access done 2 cycles after start, halfword 3; back-to-back from FIN adds no idle cycle.
// Backpressure: busy high during LO/HI; start is only accepted in IDLE or FIN, otherwise dropped.
// Ports: clk, reset (async active-high) plain; request, result and memory byte port via bus (slave).
module mem_seq_unit #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input logic          clk,
  input logic          reset,
  mem_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t          state_q, state_d;
  logic            st_q, st_d;
  logic            sz_q, sz_d;
  logic [AW-1:0]   base_q, base_d;
  logic [2*W-1:0]  wdata_q, wdata_d;
  logic [2*W-1:0]  rdata_q, rdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    mwdata_q, mwdata_d;
  logic            wen_q, wen_d;
  logic            to_reg_q, to_reg_d;
  logic            done_q, done_d;
  logic            accept;

  // A new request can only be taken when no access is in flight.
  assign accept = bus.start && (state_q == IDLE || state_q == FIN);

  // Memory-side outputs are registered and computed from the next state,
  // so they are glitch-free and drop to 0 the moment reset asserts.
  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    sz_d     = sz_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    mwdata_d = mwdata_q;
    wen_d    = 1'b0;
    to_reg_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      LO: begin
        if (!st_q) begin
          rdata_d[W-1:0] = bus.mem_rdata;
          // Byte loads zero-extend into the upper half.
          if (!sz_q) rdata_d[2*W-1:W] = '0;
        end
        if (sz_q) begin
          state_d  = HI;
          addr_d   = base_q + AW'(1);   // wraps modulo 2^AW
          wen_d    = st_q;
          to_reg_d = !st_q;
          if (st_q) mwdata_d = wdata_q[2*W-1:W];
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      HI: begin
        if (!st_q) rdata_d[2*W-1:W] = bus.mem_rdata;
        state_d = FIN;
        done_d  = 1'b1;
      end
      FIN:     state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the FIN->IDLE fall-through for back-to-back requests.
    if (accept) begin
      state_d  = LO;
      st_d     = bus.is_store;
      sz_d     = bus.size;
      base_d   = bus.base_addr;
      wdata_d  = bus.wdata;
      addr_d   = bus.base_addr;
      wen_d    = bus.is_store;
      to_reg_d = !bus.is_store;
      if (bus.is_store) mwdata_d = bus.wdata[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      st_q     <= 1'b0;
      sz_q     <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      mwdata_q <= '0;
      wen_q    <= 1'b0;
      to_reg_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      sz_q     <= sz_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      mwdata_q <= mwdata_d;
      wen_q    <= wen_d;
      to_reg_q <= to_reg_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = (state_q == LO) || (state_q == HI);
  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = mwdata_q;
  assign bus.mem_wen    = wen_q;
  assign bus.mem_to_reg = to_reg_q;

endmodule

// File: tb/tb_mem_seq_unit.sv
// Bench for mem_seq_unit: byte-wide memory attached, requests checked against a byte-array reference.
// Latency: every request is checked cycle by cycle (LO, optional HI, FIN).
// Backpressure: random start pulses during busy must be ignored.
module tb_mem_seq_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_seq_unit_if #(.W(8), .AW(8)) bus ();

  mem_seq_unit #(.W(8), .AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Data memory attached to the sequencer: combinational read, clocked write.
  logic [7:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;

  // Reference: what memory should contain and what rdata should hold.
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_rdata = 16'h0;
  int n_chk = 0, n_pass = 0;
  int n_done = 0, exp_done = 0;

  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Issue one request at a negedge; returns at the negedge inside the FIN cycle.
  task automatic do_req(input bit st, input bit sz, input logic [7:0] b, input logic [15:0] wd);
    logic [7:0] b1;
    b1 = b + 8'd1;
    bus.start = 1'b1; bus.is_store = st; bus.size = sz; bus.base_addr = b; bus.wdata = wd;
    @(negedge clk);
    // Inputs other than start are only sampled on acceptance; scramble them.
    bus.is_store = 1'($urandom); bus.size = 1'($urandom);
    bus.base_addr = 8'($urandom); bus.wdata = 16'($urandom);
    chk("lo_busy", bus.busy, 1);
    chk("lo_done", bus.done, 0);
    chk("lo_addr", bus.mem_addr, b);
    chk("lo_wen", bus.mem_wen, st);
    chk("lo_toreg", bus.mem_to_reg, !st);
    if (st) chk("lo_wdata", bus.mem_wdata, wd[7:0]);
    bus.start = 1'($urandom);
    if (sz) begin
      @(negedge clk);
      chk("hi_busy", bus.busy, 1);
      chk("hi_done", bus.done, 0);
      chk("hi_addr", bus.mem_addr, b1);
      chk("hi_wen", bus.mem_wen, st);
      chk("hi_toreg", bus.mem_to_reg, !st);
      if (st) chk("hi_wdata", bus.mem_wdata, wd[15:8]);
      bus.start = 1'($urandom);
    end
    // Reference update at the level of whole requests.
    if (st) begin
      ref_mem[b] = wd[7:0];
      if (sz) ref_mem[b1] = wd[15:8];
    end else begin
      exp_rdata = sz ? {ref_mem[b1], ref_mem[b]} : {8'h00, ref_mem[b]};
    end
    exp_done++;
    @(negedge clk);
    chk("fin_done", bus.done, 1);
    chk("fin_busy", bus.busy, 0);
    chk("fin_wen", bus.mem_wen, 0);
    chk("fin_toreg", bus.mem_to_reg, 0);
    chk("fin_addr", bus.mem_addr, sz ? b1 : b);
    chk("fin_rdata", bus.rdata, exp_rdata);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 0);
    chk({tag, "_wen"}, bus.mem_wen, 0);
    chk({tag, "_toreg"}, bus.mem_to_reg, 0);
  endtask

  initial begin
    int nmis;
    logic [15:0] wd;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.size = 1'b0;
    bus.base_addr = 8'h0; bus.wdata = 16'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed cases from the plan.
    do_req(1'b1, 1'b1, 8'h10, 16'hBEEF);
    do_req(1'b0, 1'b1, 8'h10, 16'h0000);
    chk("ld_hw_beef", bus.rdata, 16'hBEEF);
    idle(2);
    do_req(1'b0, 1'b0, 8'h11, 16'h0000);
    chk("ld_byte_be", bus.rdata, 16'h00BE);
    idle(1);
    do_req(1'b1, 1'b1, 8'hFF, 16'h1234);
    chk("wrap_ff", mem[8'hFF], 8'h34);
    chk("wrap_00", mem[8'h00], 8'h12);
    chk("st_keeps_rdata", bus.rdata, 16'h00BE);

    // Randomized traffic, mixing back-to-back and idle gaps.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hF8, 8'hFF)) : 8'($urandom_range(0, 15));
      do_req(1'($urandom), 1'($urandom), b, 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    // Asynchronous reset during HI of a halfword store to 0x20.
    wd = 16'($urandom);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.size = 1'b1; bus.base_addr = 8'h20; bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_hi_addr", bus.mem_addr, 8'h21);
    reset = 1'b1;
    #1;
    chk_outputs_zero("abort");
    ref_mem[8'h20] = wd[7:0];
    exp_rdata = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_20", mem[8'h20], ref_mem[8'h20]);
    chk("abort_21", mem[8'h21], ref_mem[8'h21]);

    // start coincident with reset: request dropped.
    bus.start = 1'b1; bus.is_store = 1'b1; bus.size = 1'b0; bus.base_addr = 8'h30;
    bus.wdata = {8'h00, ~ref_mem[8'h30]};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", bus.busy, 0);
    chk("rst_start_wen", bus.mem_wen, 0);
    @(negedge clk);
    chk("rst_start_mem", mem[8'h30], ref_mem[8'h30]);

    // Whole-memory and done-pulse accounting.
    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_final_mismatches", nmis, 0);
    chk("done_count", n_done, exp_done);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_seq_unit.md
Name: mem_seq_unit

Overview:
- Load/store sequencer directly upstream of the 8-bit data memory.
- Accepts byte or 16-bit halfword load/store requests from the core control path and issues one byte access per cycle to data memory.
- For loads, gathers memory read bytes into a 16-bit result; for stores, splits the write data into bytes.
- Provides a start/busy/done handshake so the core can stall while a halfword access completes.

Parameters:
- W, 8, data memory word (byte) width.
- AW, 8, data memory address width; addresses wrap modulo 2^AW.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled on the rising edge.
- is_store  input  1  1 = store, 0 = load; sampled with start.
- size  input  1  0 = byte, 1 = halfword; sampled with start.
- base_addr  input  AW  address of the low byte.
- wdata  input  2W  store data; low byte goes to base_addr, high byte to base_addr+1.
- busy  output  1  high while an access is in progress.
- done  output  1  one-cycle completion pulse.
- rdata  output  2W  load result.
- mem_addr  output  AW  to data memory address input.
- mem_wdata  output  W  to data memory write data input.
- mem_wen  output  1  to data memory write enable.
- mem_to_reg  output  1  to data memory read select.
- mem_rdata  input  W  from data memory output; combinational in the same cycle as mem_addr.

Behaviour:
- Reset: async, active-high. State=IDLE; busy=0, done=0, rdata=0, mem_addr=0, mem_wdata=0, mem_wen=0, mem_to_reg=0; internal request registers cleared.
- States:
  - IDLE: waiting for a request.
  - LO: low-byte access.
  - HI: high-byte access.
  - FIN: completion cycle.
- Acceptance:
  - start=1 at a rising edge while in IDLE or FIN: latch is_store, size, base_addr, wdata; go to LO.
  - start while in LO or HI is ignored. No queueing.
- LO:
  - mem_addr = latched base.
  - Store: mem_wen=1, mem_wdata=wdata[W-1:0], mem_to_reg=0.
  - Load: mem_wen=0, mem_to_reg=1; at the edge, rdata[W-1:0] <= mem_rdata.
  - Next state: HI if size=1, else FIN.
- HI:
  - mem_addr = base+1 modulo 2^AW (0xFF wraps to 0x00).
  - Store: mem_wen=1, mem_wdata=wdata[2W-1:W].
  - Load: mem_to_reg=1; at the edge, rdata[2W-1:W] <= mem_rdata.
  - Next state: FIN.
- FIN:
  - done=1; mem_wen=0, mem_to_reg=0; mem_addr holds its last value.
  - Next state: LO if start=1, else IDLE.
- Output timing:
  - busy = (state==LO || state==HI), decoded from registered state.
  - mem_wen and mem_to_reg are high only in LO/HI, so no write strobe is issued outside an accepted request.
- Byte load: rdata[2W-1:W] is cleared to 0 on the LO edge (zero-extend). rdata is stable from FIN until the next load's LO edge; a store leaves rdata unchanged.
- Latency, with start at edge 0:
  - Byte access: LO in cycle 1, done in cycle 2.
  - Halfword access: LO in cycle 1, HI in cycle 2, done in cycle 3.
  - Back-to-back requests from FIN add no idle cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A halfword store interrupted after LO leaves only the low byte written; this is accepted behaviour. No done pulse is issued for the aborted request.
- start together with reset: reset wins; the request is dropped.

Test Plan:
- Reset, then halfword store: start, is_store=1, size=1, base=0x10, wdata=0xBEEF -> cycle 1: addr 0x10, wen, wdata 0xEF; cycle 2: addr 0x11, wen, wdata 0xBE; cycle 3: done=1, busy=0.
- Halfword load from 0x10 with the memory model holding the above -> rdata=0xBEEF when done=1 in cycle 3; mem_to_reg=1 only in cycles 1-2.
- Byte load at 0x11 after rdata=0xBEEF -> done in cycle 2; rdata=0x00BE; HI state never entered.
- Wrap: halfword store base=0xFF, wdata=0x1234 -> 0x34 written at 0xFF, 0x12 at 0x00.
- Back-to-back with start held in FIN and start pulsed during LO/HI -> the second request enters LO the cycle after FIN; starts during busy are ignored (exactly two done pulses in total).
- Reset asserted asynchronously in HI of a halfword store to 0x20 -> outputs 0 immediately; 0x20 written, 0x21 unchanged; no done pulse.
